clk_count_monitor: RTL and testbench

Parametrised, multi-channel successor to the single-counter clocking example logic. Runs in one clock domain: clk, the generated system clock.
- Contains a configurable-depth reset synchroniser driven by lock loss and a counter reset.
- Provides per-channel free-running event counters with heartbeat MSBs.
- Provides a windowed tick-rate measurement engine with a valid/ack handshake, used by board bring-up firmware to verify clock health.
- Channel tick inputs are single-cycle pulses already synchronised into clk (by toggle synchronisers upstream).

---
 rtl/clk_count_monitor.sv | 154 +++++++++++++++
 tb/tb_clk_count_monitor.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/clk_count_monitor.sv
// Multi-channel clock monitor: reset synchroniser, heartbeat counters and windowed tick-rate measurement.
// Optional CLK_MON_THRESH_EN adds per-channel frequency-error flags against thr_lo/thr_hi.
module clk_count_monitor #(
  parameter int NUM_CH      = 2,
  parameter int C_W         = 16,
  parameter int SYNC_STAGES = 4,
  parameter int WINDOW      = 1000,
  parameter int SETTLE      = 8
) (
  input  logic                  clk,
  input  logic                  reset_int,
  input  logic                  locked,
  input  logic                  counter_reset,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic [NUM_CH-1:0]     ch_tick,
  output logic [NUM_CH-1:0]     count_msb,
  output logic                  rst_out,
  output logic [NUM_CH*C_W-1:0] meas_data,
  output logic                  meas_valid,
  input  logic                  meas_ack,
  output logic                  meas_overrun,
  output logic                  lock_lost,
  input  logic                  sticky_clr,
  input  logic [C_W-1:0]        thr_lo,
  input  logic [C_W-1:0]        thr_hi,
  output logic [NUM_CH-1:0]     freq_err
);

  typedef enum logic [1:0] {RESET_HOLD, ARM, MEASURE} state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [15:0] WIN_LAST    = 16'(WINDOW - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [C_W-1:0]         hb_q    [NUM_CH];
  logic [C_W-1:0]         acc_q   [NUM_CH];
  logic [C_W-1:0]         acc_nxt [NUM_CH];
  logic [NUM_CH*C_W-1:0]  acc_flat;
  state_t                 state_q, state_d;
  logic [7:0]             settle_q;
  logic [15:0]            win_q;
  logic                   complete;

  // Lock loss or a counter restart reloads the whole chain; release shifts zeros through.
  always_ff @(posedge clk or posedge reset_int) begin
    if (reset_int)                   sync_q <= '1;
    else if (!locked || counter_reset) sync_q <= '1;
    else                             sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset_int) begin
    if (reset_int) begin
      for (int i = 0; i < NUM_CH; i++) hb_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rst_out)                     hb_q[i] <= '0;
        else if (ch_en[i] && ch_tick[i]) hb_q[i] <= hb_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    count_msb = '0;
    for (int i = 0; i < NUM_CH; i++) count_msb[i] = hb_q[i][C_W-1];
  end

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      RESET_HOLD: state_d = ARM;
      ARM:        if (settle_q == SETTLE_LAST) state_d = MEASURE;
      MEASURE:    complete = (win_q == WIN_LAST);
      default:    state_d = RESET_HOLD;
    endcase
    if (rst_out) begin
      state_d  = RESET_HOLD;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_int) begin
    if (reset_int) begin
      state_q  <= RESET_HOLD;
      settle_q <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= (rst_out || state_q != ARM) ? 8'd0 : settle_q + 8'd1;
      if (rst_out || state_q != MEASURE || complete) win_q <= '0;
      else                                           win_q <= win_q + 16'd1;
    end
  end

  // Next accumulator value includes the current tick, so a completion latches it too.
  always_comb begin
    acc_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_nxt[i] = acc_q[i];
      if (ch_en[i] && ch_tick[i] && acc_q[i] != {C_W{1'b1}}) acc_nxt[i] = acc_q[i] + 1'b1;
      acc_flat[i*C_W +: C_W] = acc_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge reset_int) begin
    if (reset_int) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rst_out || state_q != MEASURE || complete) acc_q[i] <= '0;
        else                                           acc_q[i] <= acc_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset_int) begin
    if (reset_int) begin
      meas_data    <= '0;
      meas_valid   <= 1'b0;
      meas_overrun <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      if (complete) begin
        meas_data  <= acc_flat;
        meas_valid <= 1'b1;
      end else if (meas_ack) begin
        meas_valid <= 1'b0;
      end
      // Set beats clear when both land on the same edge.
      if (complete && meas_valid && !meas_ack) meas_overrun <= 1'b1;
      else if (sticky_clr)                     meas_overrun <= 1'b0;
      if (state_q == MEASURE && !locked)       lock_lost <= 1'b1;
      else if (sticky_clr)                     lock_lost <= 1'b0;
    end
  end

`ifdef CLK_MON_THRESH_EN
  always_ff @(posedge clk or posedge reset_int) begin
    if (reset_int) begin
      freq_err <= '0;
    end else if (complete) begin
      for (int i = 0; i < NUM_CH; i++)
        freq_err[i] <= (acc_nxt[i] < thr_lo) || (acc_nxt[i] > thr_hi);
    end
  end
`else
  logic unused_thr;
  assign unused_thr = ^{thr_lo, thr_hi};
  assign freq_err   = '0;
`endif

endmodule

// File: tb/tb_clk_count_monitor.sv
// Directed bench: main instance (WINDOW=16, SETTLE=2) plus a narrow instance (C_W=4, WINDOW=32) for wrap/saturate.
module tb_clk_count_monitor;

  logic        clk = 1'b0;
  logic        reset_int, locked, counter_reset, meas_ack, sticky_clr;
  logic [1:0]  ch_en, ch_tick, count_msb, freq_err;
  logic        rst_out, meas_valid, meas_overrun, lock_lost;
  logic [31:0] meas_data;
  logic [15:0] thr_lo, thr_hi;

  logic [1:0]  s_en, s_tick, s_count_msb, s_freq_err;
  logic        s_rst_out, s_meas_valid, s_meas_overrun, s_lock_lost;
  logic [7:0]  s_meas_data;
  logic [3:0]  s_thr_lo, s_thr_hi;

  logic [1:0]  phase = 2'd0;
  int          e = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;
  always @(negedge clk) phase = phase + 2'd1;
  assign ch_tick = {phase == 2'd0, 1'b1};
  assign s_tick  = 2'b11;

  clk_count_monitor #(.NUM_CH(2), .C_W(16), .SYNC_STAGES(4), .WINDOW(16), .SETTLE(2)) dut (
    .clk(clk), .reset_int(reset_int), .locked(locked), .counter_reset(counter_reset),
    .ch_en(ch_en), .ch_tick(ch_tick), .count_msb(count_msb), .rst_out(rst_out),
    .meas_data(meas_data), .meas_valid(meas_valid), .meas_ack(meas_ack),
    .meas_overrun(meas_overrun), .lock_lost(lock_lost), .sticky_clr(sticky_clr),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .freq_err(freq_err));

  clk_count_monitor #(.NUM_CH(2), .C_W(4), .SYNC_STAGES(4), .WINDOW(32), .SETTLE(2)) dut_small (
    .clk(clk), .reset_int(reset_int), .locked(locked), .counter_reset(counter_reset),
    .ch_en(s_en), .ch_tick(s_tick), .count_msb(s_count_msb), .rst_out(s_rst_out),
    .meas_data(s_meas_data), .meas_valid(s_meas_valid), .meas_ack(1'b0),
    .meas_overrun(s_meas_overrun), .lock_lost(s_lock_lost), .sticky_clr(1'b0),
    .thr_lo(s_thr_lo), .thr_hi(s_thr_hi), .freq_err(s_freq_err));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to edge number n (counted from reset release), sampling 1 ns after it.
  task automatic step_to(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  initial begin
    logic [1:0] exp_ferr;
`ifdef CLK_MON_THRESH_EN
    exp_ferr = 2'b10;
`else
    exp_ferr = 2'b00;
`endif
    reset_int = 1'b1; locked = 1'b1; counter_reset = 1'b0; meas_ack = 1'b0; sticky_clr = 1'b0;
    ch_en = 2'b11; s_en = 2'b01; thr_lo = 16'd10; thr_hi = 16'd20; s_thr_lo = 4'd0; s_thr_hi = 4'd15;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rst_out", rst_out, 1);
    check("rst_outputs", {count_msb, meas_data, meas_valid, meas_overrun, lock_lost, freq_err}, 0);

    reset_int = 1'b0;
    e = 0;
    step_to(3);  check("rst_out_edge3", rst_out, 1);
    check("valid_during_sync", meas_valid, 0);
    step_to(4);  check("rst_out_edge4", rst_out, 0);

    step_to(11); check("hb_msb_k7", s_count_msb, 2'b00);
    step_to(12); check("hb_msb_k8", s_count_msb, 2'b01);
    step_to(19); check("hb_msb_k15", s_count_msb, 2'b01);
    step_to(20); check("hb_msb_wrap", s_count_msb, 2'b00);
    check("hb_msb_wide", count_msb, 2'b00);

    step_to(22); check("valid_edge22", meas_valid, 0);
    step_to(23); check("valid_edge23", meas_valid, 1);
    check("data_win1", meas_data, {16'd4, 16'd16});
    check("freq_err_win1", freq_err, exp_ferr);
    check("overrun_win1", meas_overrun, 0);

    step_to(38); check("small_valid_e38", s_meas_valid, 0);
    check("overrun_e38", meas_overrun, 0);
    step_to(39); check("small_valid_e39", s_meas_valid, 1);
    check("small_data_sat", s_meas_data, {4'd0, 4'd15});
    check("overrun_set", meas_overrun, 1);
    check("data_win2", meas_data, {16'd4, 16'd16});

    sticky_clr = 1'b1;
    step_to(40); check("overrun_clr", meas_overrun, 0);
    sticky_clr = 1'b0; meas_ack = 1'b1;
    step_to(41); check("ack_clears_valid", meas_valid, 0);
    check("data_held_ack", meas_data, {16'd4, 16'd16});
    meas_ack = 1'b0;

    step_to(55); check("valid_win3", meas_valid, 1);
    check("overrun_win3", meas_overrun, 0);
    step_to(70); meas_ack = 1'b1;
    step_to(71); check("ack_coincide_valid", meas_valid, 1);
    check("ack_coincide_ovr", meas_overrun, 0);
    meas_ack = 1'b0;

    step_to(78); locked = 1'b0;
    step_to(79); check("lock_lost_set", lock_lost, 1);
    check("lock_rst_out", rst_out, 1);
    locked = 1'b1;
    step_to(82); check("lock_rst_e82", rst_out, 1);
    check("valid_kept_reset", meas_valid, 1);
    check("data_kept_reset", meas_data, {16'd4, 16'd16});
    step_to(83); check("lock_rst_e83", rst_out, 0);
    meas_ack = 1'b1;
    step_to(84); check("ack_after_lock", meas_valid, 0);
    meas_ack = 1'b0;
    step_to(101); check("relock_valid_e101", meas_valid, 0);
    step_to(102); check("relock_valid_e102", meas_valid, 1);
    check("relock_data_full", meas_data, {16'd4, 16'd16});
    check("lock_lost_sticky", lock_lost, 1);
    check("overrun_relock", meas_overrun, 0);

    sticky_clr = 1'b1; locked = 1'b0;
    step_to(103); check("set_beats_clr", lock_lost, 1);
    locked = 1'b1;
    step_to(104); check("lock_lost_clr", lock_lost, 0);
    sticky_clr = 1'b0;

    step_to(108); check("cr_pre", rst_out, 0);
    counter_reset = 1'b1;
    step_to(109); check("cr_rst_out", rst_out, 1);
    counter_reset = 1'b0;
    step_to(112); check("cr_rst_e112", rst_out, 1);
    step_to(113); check("cr_rst_e113", rst_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
